retospect_bs_loader: RTL and testbench
======================================

Name: retospect_bs_loader

Overview:
Host-side driver for the neurochip configuration shift chain. It accepts configuration bytes over a valid/ready handshake and serializes them LSB-first onto the chain's serial input, asserting config enable for each shifted bit. At the same time it captures the bits leaving the chain's tail as readback bytes. After CHAIN_LEN bits it issues a reset_nn pulse and reports done.

Parameters:
CHAIN_LEN, 352, total chain bits (48 clockbox + 16 cells x 19); must be >= 1
NN_CYCLES, 1, reset_nn_o pulse width in cycles; must be >= 1
CNT_W, 9, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a load; ignored while busy=1
in_data  in  8  config byte; bit 0 is shifted first
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts in_data this cycle
cfg_en_o  out  1  to chain config_en; registered
bs_o  out  1  to chain bs_in; registered, changes together with cfg_en_o
bs_i  in  1  from chain tail bs_out
rb_data  out  8  readback byte, LSB = first bit out of the chain
rb_valid  out  1  one-cycle strobe; rb_data valid
reset_nn_o  out  1  to chain reset_nn
busy  out  1  high from the accepted start until done rises
done  out  1  level; high after load completes, cleared by the next accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; bit_cnt 0; shift and readback registers 0. Reset mid-load aborts immediately. No partial rb_valid is issued.
- States: IDLE, LOAD, SHIFT, NN, DONE. DONE behaves as IDLE with done=1.
- IDLE/DONE: in_ready=0, cfg_en_o=0. On start: go to LOAD, bit_cnt<=0, done<=0, busy<=1.
- LOAD: in_ready=1, cfg_en_o=0, so the chain holds. On in_valid&in_ready: shreg<=in_data, bit_idx<=0, go to SHIFT.
- SHIFT: one bit per cycle.
  - Registered outputs: cfg_en_o=1, bs_o=shreg[0].
  - Readback capture: on each clk edge where cfg_en_o is currently 1, the chain shifts. On that same edge the loader samples bs_i, which is the bit leaving the chain, into rbreg[bit_idx]. It then increments bit_idx and bit_cnt.
  - Byte end: occurs when bit_idx reaches 8, or when bit_cnt reaches CHAIN_LEN if that comes first.
  - At byte end: cfg_en_o<=0 on the next edge, rb_data<=rbreg with unfilled upper bits 0, rb_valid pulses 1 cycle.
  - Next state: NN if bit_cnt==CHAIN_LEN, else LOAD.
- Throughput: there is a one-cycle LOAD bubble between bytes, so 9 cycles per byte when in_valid is held high. No zero-bubble path.
- Partial final byte: when CHAIN_LEN mod 8 != 0, only the low (CHAIN_LEN mod 8) bits of the last byte are shifted. The remaining bits are discarded and no extra in_ready cycle is given.
- NN: reset_nn_o=1 for exactly NN_CYCLES cycles, with cfg_en_o=0. Then go to DONE: done=1, busy=0.
- in_valid outside LOAD is ignored; in_ready never rises outside LOAD.
- start while busy is ignored; it has no effect on state or counters.
- cfg_en_o and reset_nn_o are never high in the same cycle.
- Readback semantics: readback bytes of load N equal the configuration bytes of load N-1, because the chain is a CHAIN_LEN-bit FIFO. After reset the readback is zeros.

Decomposition:
- Package retospect_bs_pkg:
  - state enum
  - CLOCKBOX_BITS=48
  - CNB_BITS=19
  - default grid X_MAX=Y_MAX=4
  - derived CHAIN_LEN default
- Sub-module retospect_bs_serdes: 8-bit PISO/SIPO pair with bit_idx, load/shift/capture controls. Top holds the FSM, bit_cnt and the NN timer.

Test Plan:
- Full load after reset: 44 bytes 0x01..0x2C with in_valid always high, checked against a behavioural 352-bit shift model.
  - 352 cfg_en_o cycles total.
  - Chain contents match the model.
  - All rb_data=0x00.
  - reset_nn_o high for 1 cycle, then done=1, busy=0.
- Second load with bytes 0xA5 repeated -> the 44 rb_data values equal 0x01..0x2C in order.
- Stalls: in_valid dropped for 5 cycles between each byte -> cfg_en_o stays 0 during the gaps and the final chain image is unchanged versus the no-stall run.
- CHAIN_LEN=12 with bytes 0xFF, 0xFF:
  - 8 + 4 shifted bits.
  - Second rb_data has its upper 4 bits 0.
  - Only 2 in_ready handshakes occur.
- Reset asserted after the 100th shifted bit -> all outputs 0 within the same cycle (async). A new start followed by a full load completes normally.
- start pulsed during SHIFT and during NN -> no restart, and bit_cnt continues. start pulsed during DONE -> done clears and a new load begins.

Source files
------------

// File: rtl/retospect_bs_pkg.sv
// Shared types and chain geometry for the neurochip configuration bitstream loader.
package retospect_bs_pkg;

  localparam int unsigned CLOCKBOX_BITS = 48;
  localparam int unsigned CNB_BITS      = 19;
  localparam int unsigned X_MAX         = 4;
  localparam int unsigned Y_MAX         = 4;
  localparam int unsigned CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + X_MAX * Y_MAX * CNB_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StNn,
    StDone
  } bs_state_e;

endpackage

// File: rtl/retospect_bs_serdes.sv
// Byte-wide PISO/SIPO pair: holds the outgoing config byte and assembles the readback byte.
module retospect_bs_serdes (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       shift_i,
  input  logic       ser_i,
  output logic       next_bit_o,
  output logic       last_o,
  output logic [7:0] capture_o
);

  logic [7:0] shreg_q;
  logic [7:0] rbreg_q;
  logic [2:0] bit_idx_q;

  // Bit 0 is on the wire during the current shift; bit 1 is the one to present next.
  assign next_bit_o = shreg_q[1];
  assign last_o     = (bit_idx_q == 3'd7);

  always_comb begin
    capture_o = rbreg_q;
    capture_o[bit_idx_q] = ser_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= 8'h00;
      rbreg_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else if (load_i) begin
      shreg_q   <= load_data_i;
      rbreg_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else if (shift_i) begin
      shreg_q   <= {1'b0, shreg_q[7:1]};
      rbreg_q   <= capture_o;
      bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

endmodule

// File: rtl/retospect_bs_loader.sv
// Host-side loader: serializes config bytes onto the chain, captures readback, pulses reset_nn.
module retospect_bs_loader
  import retospect_bs_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned NN_CYCLES = 1,
  parameter int unsigned CNT_W     = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_en_o,
  output logic       bs_o,
  input  logic       bs_i,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       reset_nn_o,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NnW = (NN_CYCLES > 1) ? $clog2(NN_CYCLES) : 1;

  bs_state_e        state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [NnW-1:0]   nn_cnt_q;
  logic             cfg_en_q, bs_q, rb_valid_q, reset_nn_q, busy_q, done_q;
  logic [7:0]       rb_data_q;

  logic       accept, ser_next, ser_last, chain_end, byte_end;
  logic [7:0] capture;

  assign in_ready  = (state_q == StLoad);
  assign accept    = in_ready & in_valid;
  assign chain_end = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  // A short final byte ends as soon as the chain is full.
  assign byte_end  = ser_last | chain_end;

  retospect_bs_serdes u_serdes (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .load_data_i (in_data),
    .shift_i     (cfg_en_q),
    .ser_i       (bs_i),
    .next_bit_o  (ser_next),
    .last_o      (ser_last),
    .capture_o   (capture)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      nn_cnt_q   <= '0;
      cfg_en_q   <= 1'b0;
      bs_q       <= 1'b0;
      rb_data_q  <= 8'h00;
      rb_valid_q <= 1'b0;
      reset_nn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StLoad;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StLoad: begin
          if (in_valid) begin
            state_q  <= StShift;
            cfg_en_q <= 1'b1;
            bs_q     <= in_data[0];
          end
        end
        StShift: begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (byte_end) begin
            cfg_en_q   <= 1'b0;
            rb_data_q  <= capture;
            rb_valid_q <= 1'b1;
            if (chain_end) begin
              state_q    <= StNn;
              reset_nn_q <= 1'b1;
              nn_cnt_q   <= '0;
            end else begin
              state_q <= StLoad;
            end
          end else begin
            bs_q <= ser_next;
          end
        end
        StNn: begin
          if (nn_cnt_q == NnW'(NN_CYCLES - 1)) begin
            state_q    <= StDone;
            reset_nn_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            nn_cnt_q <= nn_cnt_q + NnW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_en_o   = cfg_en_q;
  assign bs_o       = bs_q;
  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign reset_nn_o = reset_nn_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench: full-size chain plus a 12-bit chain, each with a behavioural shift-chain model.
module tb_retospect_bs_loader;

  localparam int CL  = 352;
  localparam int SCL = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start, in_valid, in_ready, cfg_en_o, bs_o, bs_i, rb_valid, reset_nn_o, busy, done;
  logic [7:0] in_data, rb_data;
  logic       s_start, s_in_valid, s_in_ready, s_cfg_en_o, s_bs_o, s_bs_i, s_rb_valid;
  logic       s_reset_nn_o, s_busy, s_done;
  logic [7:0] s_in_data, s_rb_data;

  retospect_bs_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_en_o(cfg_en_o), .bs_o(bs_o), .bs_i(bs_i), .rb_data(rb_data),
    .rb_valid(rb_valid), .reset_nn_o(reset_nn_o), .busy(busy), .done(done)
  );

  retospect_bs_loader #(.CHAIN_LEN(12), .NN_CYCLES(1), .CNT_W(4)) u_dut_short (
    .clk(clk), .reset(reset), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .cfg_en_o(s_cfg_en_o), .bs_o(s_bs_o), .bs_i(s_bs_i),
    .rb_data(s_rb_data), .rb_valid(s_rb_valid), .reset_nn_o(s_reset_nn_o), .busy(s_busy),
    .done(s_done)
  );

  int checks = 0;
  int failures = 0;

  logic [CL-1:0]  chain = '0;
  logic [SCL-1:0] s_chain = '0;
  logic [CL-1:0]  img_ref;
  assign bs_i   = chain[CL-1];
  assign s_bs_i = s_chain[SCL-1];

  int cyc = 0, start_cyc = 0;
  int cfg_cnt, hs_cnt, nn_hi, viol, stall_cnt;
  int s_cfg_cnt, s_hs_cnt, s_ready_cnt;
  logic [7:0] rbq[$];
  logic [7:0] s_rbq[$];
  logic [7:0] src [44];

  // Chain model: shifts on every edge where config enable is high; tail is the top bit.
  always @(posedge clk) begin
    cyc++;
    if (cfg_en_o) begin
      chain <= {chain[CL-2:0], bs_o};
      cfg_cnt++;
    end
    if (s_cfg_en_o) begin
      s_chain <= {s_chain[SCL-2:0], s_bs_o};
      s_cfg_cnt++;
    end
    if (in_ready && in_valid) hs_cnt++;
    if (in_ready && !in_valid) stall_cnt++;
    if (s_in_ready && s_in_valid) s_hs_cnt++;
    if (s_in_ready) s_ready_cnt++;
  end

  always @(negedge clk) begin
    if (rb_valid) rbq.push_back(rb_data);
    if (s_rb_valid) s_rbq.push_back(s_rb_data);
    if (reset_nn_o) nn_hi++;
    if ((cfg_en_o && reset_nn_o) || (cfg_en_o && in_ready)) viol++;
  end

  function automatic logic [CL-1:0] exp_image();
    logic [CL-1:0] img;
    img = '0;
    for (int k = 0; k < CL; k++) img[CL-1-k] = src[k/8][k%8];
    return img;
  endfunction

  task automatic clear_mon();
    cfg_cnt = 0; hs_cnt = 0; nn_hi = 0; viol = 0; stall_cnt = 0;
    rbq.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_bytes(input int gap);
    for (int j = 0; j < 44; j++) begin
      int t;
      t = 0;
      in_data = src[j];
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      checks++;
      if (t >= 200) begin
        failures++;
        $display("FAIL feed_ready byte=%0d in_ready=%b want 1", j, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (8 + gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int t;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    lat = cyc - start_cyc;
    checks++;
    if (t >= 200) begin failures++; $display("FAIL done_wait done=%b want 1", done); end
  endtask

  task automatic check_rb(input string name, input logic [7:0] base, input logic inc);
    int bad, first;
    logic [7:0] want;
    bad = 0; first = -1;
    for (int j = 0; j < rbq.size(); j++) begin
      want = inc ? 8'(base + 8'(j)) : base;
      if (rbq[j] !== want) begin bad++; if (first < 0) first = j; end
    end
    checks++;
    if (rbq.size() != 44 || bad != 0) begin
      failures++;
      $display("FAIL %s count=%0d want 44 mismatched=%0d want 0 first_bad=%0d", name,
               rbq.size(), bad, first);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, cfg_en_o, bs_o, rb_valid, reset_nn_o, busy, done, rb_data} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0", {in_ready, cfg_en_o, bs_o, rb_valid,
               reset_nn_o, busy, done, rb_data});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int lat;
    for (int j = 0; j < 44; j++) src[j] = 8'(j + 1);
    img_ref = exp_image();
    clear_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_accept busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    feed_bytes(0);
    wait_done(lat);
    checks++;
    if (lat != 398) begin failures++; $display("FAIL load_latency got %0d want 398", lat); end
    checks++;
    if (cfg_cnt != 352) begin failures++; $display("FAIL cfg_en_cycles got %0d want 352", cfg_cnt); end
    checks++;
    if (hs_cnt != 44) begin failures++; $display("FAIL handshakes got %0d want 44", hs_cnt); end
    checks++;
    if (chain !== img_ref) begin
      failures++;
      $display("FAIL chain_image got %h want %h", chain, img_ref);
    end
    check_rb("readback_zero", 8'h00, 1'b0);
    checks++;
    if (nn_hi != 1) begin failures++; $display("FAIL reset_nn_width got %0d want 1", nn_hi); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_state done=%b busy=%b in_ready=%b want 1 0 0", done, busy, in_ready);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL exclusivity got %0d want 0", viol); end
  endtask

  task automatic test_readback();
    int lat;
    for (int j = 0; j < 44; j++) src[j] = 8'hA5;
    clear_mon();
    pulse_start();
    feed_bytes(0);
    wait_done(lat);
    check_rb("readback_prev_load", 8'h01, 1'b1);
    checks++;
    if (chain !== exp_image()) begin
      failures++;
      $display("FAIL chain_a5 got %h want %h", chain, exp_image());
    end
  endtask

  task automatic test_stalls();
    int lat;
    for (int j = 0; j < 44; j++) src[j] = 8'(j + 1);
    clear_mon();
    pulse_start();
    feed_bytes(5);
    wait_done(lat);
    checks++;
    if (chain !== img_ref) begin
      failures++;
      $display("FAIL stall_chain got %h want %h", chain, img_ref);
    end
    check_rb("stall_readback", 8'hA5, 1'b0);
    checks++;
    if (stall_cnt != 215 || viol != 0 || cfg_cnt != 352) begin
      failures++;
      $display("FAIL stall_gaps stalls=%0d viol=%0d cfg=%0d want 215 0 352", stall_cnt, viol,
               cfg_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    clear_mon();
    fork
      begin
        pulse_start();
        feed_bytes(0);
        wait_done(lat);
      end
      begin
        int t;
        t = 0;
        while (cfg_cnt < 20 && t < 1000) begin @(negedge clk); t++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!reset_nn_o && t < 1000) begin @(negedge clk); t++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    checks++;
    if (cfg_cnt != 352 || hs_cnt != 44 || lat != 398) begin
      failures++;
      $display("FAIL start_ignored cfg=%0d hs=%0d lat=%0d want 352 44 398", cfg_cnt, hs_cnt, lat);
    end
    checks++;
    if (chain !== img_ref || done !== 1'b1 || nn_hi != 1) begin
      failures++;
      $display("FAIL start_ignored_end done=%b nn=%0d chain_ok=%b want 1 1 1", done, nn_hi,
               chain === img_ref);
    end
  endtask

  task automatic test_start_during_done();
    int lat;
    for (int j = 0; j < 44; j++) src[j] = 8'hA5;
    clear_mon();
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_done done=%b busy=%b in_ready=%b want 0 1 1", done, busy,
               in_ready);
    end
    feed_bytes(0);
    wait_done(lat);
    check_rb("restart_readback", 8'h01, 1'b1);
  endtask

  task automatic test_reset_midload();
    int t, lat;
    clear_mon();
    in_data = 8'h3C;
    in_valid = 1'b1;
    pulse_start();
    t = 0;
    while (cfg_cnt < 100 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (busy !== 1'b1 || t >= 2000) begin
      failures++;
      $display("FAIL midload_reach busy=%b shifts=%0d want 1 100", busy, cfg_cnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, cfg_en_o, bs_o, rb_valid, reset_nn_o, busy, done, rb_data} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset got %b want 0", {in_ready, cfg_en_o, bs_o, rb_valid,
               reset_nn_o, busy, done, rb_data});
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 44; j++) src[j] = 8'(j + 1);
    clear_mon();
    pulse_start();
    feed_bytes(0);
    wait_done(lat);
    checks++;
    if (chain !== img_ref || cfg_cnt != 352 || rbq.size() != 44) begin
      failures++;
      $display("FAIL post_reset_load cfg=%0d rb=%0d chain_ok=%b want 352 44 1", cfg_cnt,
               rbq.size(), chain === img_ref);
    end
  endtask

  task automatic s_load();
    int t;
    s_cfg_cnt = 0; s_hs_cnt = 0; s_ready_cnt = 0;
    s_rbq.delete();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      s_in_data = 8'hFF;
      s_in_valid = 1'b1;
      t = 0;
      while (!s_in_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    t = 0;
    while (!s_done && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (t >= 50) begin failures++; $display("FAIL short_done done=%b want 1", s_done); end
    s_in_valid = 1'b0;
  endtask

  task automatic test_short_chain();
    s_load();
    checks++;
    if (s_rbq.size() != 2 || s_rbq[0] !== 8'h00 || s_rbq[1] !== 8'h00) begin
      failures++;
      $display("FAIL short_first_rb count=%0d want 2 (bytes want 00 00)", s_rbq.size());
    end
    s_load();
    checks++;
    if (s_cfg_cnt != 12 || s_hs_cnt != 2 || s_ready_cnt != 2) begin
      failures++;
      $display("FAIL short_counts cfg=%0d hs=%0d ready=%0d want 12 2 2", s_cfg_cnt, s_hs_cnt,
               s_ready_cnt);
    end
    checks++;
    if (s_rbq.size() != 2) begin
      failures++;
      $display("FAIL short_rb_count got %0d want 2", s_rbq.size());
    end else if (s_rbq[0] !== 8'hFF || s_rbq[1] !== 8'h0F) begin
      failures++;
      $display("FAIL short_rb_bytes got %h %h want ff 0f", s_rbq[0], s_rbq[1]);
    end
    checks++;
    if (s_chain !== 12'hFFF) begin
      failures++;
      $display("FAIL short_chain got %h want fff", s_chain);
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00;
    test_reset();
    test_full_load();
    test_readback();
    test_stalls();
    test_start_ignored();
    test_start_during_done();
    test_reset_midload();
    test_short_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
